plab4_net_router_input_term_tdm_queue: RTL and testbench

Per-domain input queue and time-division slot scheduler sitting directly upstream of the timing-protected router input terminal control. Buffers terminal-injected packets in two isolated FIFOs (domain 0, domain 1), generates the one-hot `domain0`/`domain1` slot signals, and presents only the active domain's head packet and destination to the control stage. Cross-domain interference is limited to the fixed slot schedule, which makes it the timing-channel protection point for terminal injection.

---
 rtl/plab4_net_router_input_term_tdm_queue_pkg.sv | 23 ++
 rtl/plab4_net_router_input_term_tdm_queue_domain_fifo.sv | 56 +++++
 rtl/plab4_net_router_input_term_tdm_queue.sv | 113 +++++++++++
 tb/tb_plab4_net_router_input_term_tdm_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_input_term_tdm_queue_pkg.sv
// Shared encodings for the terminal-injection TDM queue: domain tags and slot-scheduler states.
package plab4_net_router_input_term_tdm_queue_pkg;

  localparam logic DOM0 = 1'b0;
  localparam logic DOM1 = 1'b1;

  // Bit 1 is the owning domain, bit 0 marks the guard window.
  typedef enum logic [1:0] {
    DOM0_OPEN  = 2'b00,
    DOM0_GUARD = 2'b01,
    DOM1_OPEN  = 2'b10,
    DOM1_GUARD = 2'b11
  } slot_state_e;

  function automatic logic state_domain(input slot_state_e s);
    return s[1];
  endfunction

  function automatic logic state_open(input slot_state_e s);
    return !s[0];
  endfunction

endpackage

// File: rtl/plab4_net_router_input_term_tdm_queue_domain_fifo.sv
// Single-domain circular FIFO with occupancy count; no bypass and no full-with-pop enqueue.
module plab4_net_domain_fifo
  import plab4_net_router_input_term_tdm_queue_pkg::*;
#(
  parameter  int p_depth     = 4,
  parameter  int p_width     = 44,
  localparam int c_cnt_nbits = $clog2(p_depth + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [p_width-1:0]     enq_msg,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic                   deq_en,
  output logic [p_width-1:0]     deq_msg,
  output logic                   deq_val,
  output logic [c_cnt_nbits-1:0] count
);

  localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_width-1:0]     mem [p_depth];
  logic [c_ptr_nbits-1:0] wr_ptr;
  logic [c_ptr_nbits-1:0] rd_ptr;
  logic                   do_enq;
  logic                   do_deq;

  function automatic logic [c_ptr_nbits-1:0] next_ptr(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_nbits'(p_depth - 1)) ? '0 : p + c_ptr_nbits'(1);
  endfunction

  assign enq_rdy = (count != c_cnt_nbits'(p_depth));
  assign deq_val = (count != '0);
  assign do_enq  = enq_val && enq_rdy;
  assign do_deq  = deq_en && deq_val;
  assign deq_msg = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= next_ptr(wr_ptr);
      if (do_deq) rd_ptr <= next_ptr(rd_ptr);
      if (do_enq && !do_deq)      count <= count + c_cnt_nbits'(1);
      else if (do_deq && !do_enq) count <= count - c_cnt_nbits'(1);
    end
  end

  // Storage needs no reset: the read side is qualified by count.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/plab4_net_router_input_term_tdm_queue.sv
// Per-domain input queues plus fixed round-robin slot scheduler for terminal injection.
// Optional guard window at slot end enabled by defining PLAB4_NET_TDM_GUARD_EN.
module plab4_net_router_input_term_tdm_queue
  import plab4_net_router_input_term_tdm_queue_pkg::*;
#(
  parameter  int p_router_id    = 0,
  parameter  int p_num_routers  = 8,
  parameter  int p_msg_nbits    = 44,
  parameter  int p_dest_lsb     = 42,
  parameter  int p_queue_depth  = 4,
  parameter  int p_slot_cycles  = 8,
  parameter  int p_guard_cycles = 2,
  localparam int c_dest_nbits   = $clog2(p_num_routers),
  localparam int c_cnt_nbits    = $clog2(p_queue_depth + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  input  logic                    in_val,
  output logic                    in_rdy,
  output logic [p_msg_nbits-1:0]  out_msg,
  output logic [c_dest_nbits-1:0] out_dest,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic                    domain0,
  output logic                    domain1,
  output logic [c_cnt_nbits-1:0]  count0,
  output logic [c_cnt_nbits-1:0]  count1
);

  localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_cycles - 1);

  if (p_queue_depth < 2 || p_slot_cycles < 2 || p_guard_cycles >= p_slot_cycles ||
      p_router_id >= p_num_routers || p_dest_lsb >= p_msg_nbits) begin : g_bad_cfg
    $error("plab4_net_router_input_term_tdm_queue: invalid parameter set");
  end

  slot_state_e             state;
  slot_state_e             state_next;
  logic [c_slot_nbits-1:0] slot_cnt;
  logic [c_slot_nbits-1:0] slot_next;
  logic                    window_open;
  logic                    active;

  logic                    enq_rdy0, enq_rdy1;
  logic                    deq_val0, deq_val1;
  logic [p_msg_nbits-1:0]  deq_msg0, deq_msg1;
  logic                    pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DOM0_OPEN;
      slot_cnt <= '0;
    end else begin
      state    <= state_next;
      slot_cnt <= slot_next;
    end
  end

  // Schedule advances every cycle regardless of traffic; empty slots are never skipped.
  always_comb begin
    logic dom_next;
    logic guard_next;
    slot_next  = (slot_cnt == c_slot_last) ? '0 : slot_cnt + c_slot_nbits'(1);
    dom_next   = (slot_cnt == c_slot_last) ? !state_domain(state) : state_domain(state);
    guard_next = 1'b0;
`ifdef PLAB4_NET_TDM_GUARD_EN
    guard_next = (slot_next >= c_slot_nbits'(p_slot_cycles - p_guard_cycles));
`endif
    state_next = slot_state_e'({dom_next, guard_next});
  end

  always_comb begin
    active      = state_domain(state);
    domain0     = !active;
    domain1     = active;
    window_open = state_open(state);
  end

  assign in_rdy   = (in_domain == DOM1) ? enq_rdy1 : enq_rdy0;
  assign out_val  = window_open && ((active == DOM1) ? deq_val1 : deq_val0);
  assign out_msg  = out_val ? ((active == DOM1) ? deq_msg1 : deq_msg0) : '0;
  // Shift rather than part-select so a dest field overhanging the MSB reads as zero.
  assign out_dest = c_dest_nbits'(out_msg >> p_dest_lsb);
  assign pop      = out_val && out_rdy;

  plab4_net_domain_fifo #(.p_depth(p_queue_depth), .p_width(p_msg_nbits)) fifo0 (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_msg (in_msg),
    .enq_val (in_val && (in_domain == DOM0)),
    .enq_rdy (enq_rdy0),
    .deq_en  (pop && (active == DOM0)),
    .deq_msg (deq_msg0),
    .deq_val (deq_val0),
    .count   (count0)
  );

  plab4_net_domain_fifo #(.p_depth(p_queue_depth), .p_width(p_msg_nbits)) fifo1 (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_msg (in_msg),
    .enq_val (in_val && (in_domain == DOM1)),
    .enq_rdy (enq_rdy1),
    .deq_en  (pop && (active == DOM1)),
    .deq_msg (deq_msg1),
    .deq_val (deq_val1),
    .count   (count1)
  );

endmodule

// File: tb/tb_plab4_net_router_input_term_tdm_queue.sv
// Directed bench with per-domain scoreboard queues for the terminal-injection TDM queue.
module tb_plab4_net_router_input_term_tdm_queue;

  localparam int MW    = 44;
  localparam int DL    = 42;
  localparam int DN    = 3;
  localparam int CN    = 3;
  localparam int DEPTH = 4;
`ifdef PLAB4_NET_TDM_GUARD_EN
  localparam int OPEN_CYC = 6;
`else
  localparam int OPEN_CYC = 8;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [MW-1:0] in_msg;
  logic          in_domain;
  logic          in_val;
  logic          in_rdy;
  logic [MW-1:0] out_msg;
  logic [DN-1:0] out_dest;
  logic          out_val;
  logic          out_rdy;
  logic          domain0, domain1;
  logic [CN-1:0] count0, count1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  logic [MW-1:0] q0[$];
  logic [MW-1:0] q1[$];

  plab4_net_router_input_term_tdm_queue dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_msg    (in_msg),
    .in_domain (in_domain),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .out_msg   (out_msg),
    .out_dest  (out_dest),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .domain0   (domain0),
    .domain1   (domain1),
    .count0    (count0),
    .count1    (count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] pkt(input logic [1:0] dest, input int t);
    return {dest, 42'(t)};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    cyc = 0;
  endtask

  // Scoreboard step: check occupancy/handshake, retire pops, record accepted enqueues, advance a cycle.
  task automatic tick();
    logic [MW-1:0] e;
    logic          rdy_model;
    int            sz;
    #1;
    chk("count0", 64'(count0), 64'(q0.size()));
    chk("count1", 64'(count1), 64'(q1.size()));
    rdy_model = ((in_domain ? q1.size() : q0.size()) < DEPTH);
    if (in_val) chk("in_rdy", 64'(in_rdy), 64'(rdy_model));
    if (out_val && out_rdy) begin
      sz = domain1 ? q1.size() : q0.size();
      chk("pop_has_data", 64'(sz != 0), 64'(1));
      if (sz != 0) begin
        e = domain1 ? q1.pop_front() : q0.pop_front();
        chk("out_msg", 64'(out_msg), 64'(e));
        chk("out_dest", 64'(out_dest), 64'(DN'(e >> DL)));
      end
    end
    if (in_val && rdy_model) begin
      if (in_domain) q1.push_back(in_msg);
      else           q0.push_back(in_msg);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    in_msg    = '0;
    in_domain = 1'b0;
    in_val    = 1'b0;
    out_rdy   = 1'b0;

    // Reset state and idle schedule
    do_reset();
    chk("rst_domain0", 64'(domain0), 64'(1));
    chk("rst_domain1", 64'(domain1), 64'(0));
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_msg", 64'(out_msg), 64'(0));
    chk("rst_in_rdy",  64'(in_rdy),  64'(1));
    for (int i = 0; i < 16; i++) begin
      chk("idle_domain0", 64'(domain0), 64'(cyc < 8));
      chk("idle_domain1", 64'(domain1), 64'(cyc >= 8));
      chk("idle_out_val", 64'(out_val), 64'(0));
      chk("idle_in_rdy",  64'(in_rdy),  64'(1));
      tick();
    end

    // Domain 0 packet in own slot: one-cycle latency
    do_reset();
    out_rdy = 1'b1;
    tick();
    in_val = 1'b1; in_domain = 1'b0; in_msg = pkt(2'd3, 1);
    tick();
    in_val = 1'b0;
    chk("s2_out_val",  64'(out_val),  64'(1));
    chk("s2_out_dest", 64'(out_dest), 64'(3));
    tick();
    chk("s2_count0",   64'(count0),   64'(0));
    chk("s2_out_val0", 64'(out_val),  64'(0));

    // Domain 1 packet held until its slot
    do_reset();
    out_rdy = 1'b1;
    tick();
    in_val = 1'b1; in_domain = 1'b1; in_msg = pkt(2'd2, 77);
    tick();
    in_val = 1'b0;
    while (cyc < 8) begin
      chk("s3_held_out_val", 64'(out_val), 64'(0));
      chk("s3_held_out_msg", 64'(out_msg), 64'(0));
      chk("s3_count1",       64'(count1),  64'(1));
      tick();
    end
    chk("s3_domain1",  64'(domain1),  64'(1));
    chk("s3_out_val",  64'(out_val),  64'(1));
    chk("s3_out_dest", 64'(out_dest), 64'(2));
    tick();
    chk("s3_count1_after", 64'(count1), 64'(0));

    // Fill domain 0, then drain a full slot with continuous backlog
    do_reset();
    in_val = 1'b1; in_domain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_msg = pkt(i[1:0], 100 + i);
      tick();
    end
    in_msg = pkt(2'd1, 200);
    #1;
    chk("s4_full_rdy0", 64'(in_rdy), 64'(0));
    chk("s4_count0",    64'(count0), 64'(4));
    in_domain = 1'b1; in_val = 1'b0;
    #1;
    chk("s4_rdy1", 64'(in_rdy), 64'(1));
    in_domain = 1'b0; in_val = 1'b1;
    tick();
    in_val = 1'b0;
    chk("s4_count_hold", 64'(count0), 64'(4));
    while (cyc < 16) tick();
    out_rdy = 1'b1; in_val = 1'b1; in_domain = 1'b0;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      chk("s5_out_val", 64'(out_val), 64'(k < OPEN_CYC));
      if (out_val) pops++;
      in_msg = pkt(k[1:0], 300 + k);
      tick();
    end
    in_val = 1'b0;
    chk("s5_pops",     64'(pops),    64'(OPEN_CYC));
    chk("s5_domain1",  64'(domain1), 64'(1));
    chk("s5_out_val1", 64'(out_val), 64'(0));

    // Asynchronous reset mid-operation
    do_reset();
    in_val = 1'b1; in_domain = 1'b0; in_msg = pkt(2'd1, 500);
    tick();
    in_domain = 1'b1; in_msg = pkt(2'd2, 501);
    tick();
    in_val = 1'b0;
    while (cyc < 5) tick();
    chk("s6_pre_count0", 64'(count0), 64'(1));
    chk("s6_pre_count1", 64'(count1), 64'(1));
    reset_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("s6_count0",  64'(count0),  64'(0));
    chk("s6_count1",  64'(count1),  64'(0));
    chk("s6_domain0", 64'(domain0), 64'(1));
    chk("s6_domain1", 64'(domain1), 64'(0));
    chk("s6_out_val", 64'(out_val), 64'(0));
    chk("s6_out_msg", 64'(out_msg), 64'(0));
    chk("s6_in_rdy",  64'(in_rdy),  64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      chk("s6_restart_domain1", 64'(domain1), 64'(cyc >= 8));
      chk("s6_restart_out_val", 64'(out_val), 64'(0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
